// File: rtl/gpmc_wb_bridge_pkg.sv
// gpmc_wb_bridge_pkg: bridge state encoding and GPMC/Wishbone width constants shared by all slaves
package gpmc_wb_bridge_pkg;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WR_CYC = 2'd1;
   localparam logic [1:0] ST_RD_CYC = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;
   localparam int GPMC_AW = 5;
   localparam int GPMC_DW = 16;
   localparam logic [GPMC_DW-1:0] ERR_DATA_DEF = 16'hDEAD;
endpackage

// File: rtl/gpmc_wb_bridge_sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous control strobes
module sync_2ff #(
   parameter int WIDTH = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_meta;
   always_ff @(posedge clk)
      if (!reset) begin
         r_meta <= RST_VAL;
         o_q    <= RST_VAL;
      end else begin
         r_meta <= i_d;
         o_q    <= r_meta;
      end
endmodule

// File: rtl/gpmc_wb_bridge.sv
// gpmc_wb_bridge: turns asynchronous GPMC muxed accesses into single Wishbone cycles
module gpmc_wb_bridge
   import gpmc_wb_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH = GPMC_AW,
   parameter int DATA_WIDTH = GPMC_DW,
   parameter int TIMEOUT    = 255,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA = ERR_DATA_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  gpmc_csn,
   input  logic                  gpmc_advn,
   input  logic                  gpmc_wen,
   input  logic                  gpmc_oen,
   input  logic [DATA_WIDTH-1:0] gpmc_ad_in,
   output logic [DATA_WIDTH-1:0] gpmc_ad_out,
   output logic                  gpmc_ad_oe,
   output logic [ADDR_WIDTH-1:0] wbm_address,
   output logic [DATA_WIDTH-1:0] wbm_writedata,
   input  logic [DATA_WIDTH-1:0] wbm_readdata,
   output logic                  wbm_write,
   output logic                  wbm_cycle,
   input  logic                  wbm_ack,
   output logic                  timeout_err
);
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [3:0]            w_s;
   logic                  w_csn, w_advn, w_wen, w_oen, w_wen_fall, w_oen_fall, w_busy, w_tmo;
   logic                  r_wen_prev, r_oen_prev, r_rd, r_terr;
   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
   logic [TW-1:0]         r_timer;
   sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   ({gpmc_csn, gpmc_advn, gpmc_wen, gpmc_oen}),
      .o_q   (w_s)
   );
   assign {w_csn, w_advn, w_wen, w_oen} = w_s;
   assign w_wen_fall = r_wen_prev & ~w_wen & ~w_csn;
   assign w_oen_fall = r_oen_prev & ~w_oen & ~w_csn;
   assign w_busy     = (r_state == ST_WR_CYC) || (r_state == ST_RD_CYC);
   assign w_tmo      = r_timer == TW'(TIMEOUT - 1);
   // cycle drops as soon as reset is asserted, without waiting for the edge
   assign wbm_cycle     = reset & w_busy;
   assign wbm_write     = r_state == ST_WR_CYC;
   assign wbm_address   = r_addr;
   assign wbm_writedata = r_wdata;
   assign gpmc_ad_out   = r_rdata;
   assign gpmc_ad_oe    = (r_state == ST_HOLD) & r_rd & ~w_oen & ~w_csn;
   assign timeout_err   = r_terr;
   always_ff @(posedge clk)
      if (!reset) begin
         r_wen_prev <= 1'b1;
         r_oen_prev <= 1'b1;
         r_state    <= ST_IDLE;
         r_rd       <= 1'b0;
         r_terr     <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_timer    <= '0;
      end else begin
         r_wen_prev <= w_wen;
         r_oen_prev <= w_oen;
         // address is frozen while a Wishbone cycle is in flight
         if (!w_busy && !w_advn && !w_csn) r_addr <= gpmc_ad_in[ADDR_WIDTH-1:0];
         r_timer <= !w_busy ? '0 : (r_timer != TW'(TIMEOUT)) ? r_timer + 1'b1 : r_timer;
         case (r_state)
            ST_IDLE:
               if (w_wen_fall) begin
                  r_wdata <= gpmc_ad_in;
                  r_rd    <= 1'b0;
                  r_state <= ST_WR_CYC;
               end else if (w_oen_fall) begin
                  r_rd    <= 1'b1;
                  r_state <= ST_RD_CYC;
               end
            ST_WR_CYC, ST_RD_CYC:
               if (wbm_ack) begin
                  if (r_rd) r_rdata <= wbm_readdata;
                  r_state <= ST_HOLD;
               end else if (w_tmo) begin
                  if (r_rd) r_rdata <= ERR_DATA;
                  r_terr  <= 1'b1;
                  r_state <= ST_HOLD;
               end
            default:
               if ((w_wen && w_oen) || w_csn) r_state <= ST_IDLE;
         endcase
      end
endmodule

// File: tb/tb_gpmc_wb_bridge.sv
// tb_gpmc_wb_bridge: GPMC-side directed and random accesses against a memory model and Wishbone slave
module tb_gpmc_wb_bridge;
   logic        clk = 0, reset = 0, csn = 1, advn = 1, wen = 1, oen = 1;
   logic [15:0] ad_in = 0, ad_out, wb_wdata, wb_rdata;
   logic [4:0]  wb_addr;
   logic        ad_oe, wb_write, wb_cycle, wb_ack, terr;
   int          checks = 0, failures = 0;
   int          lat = 0, cyc_cnt = 0, last_len = 0, starts = 0, stab_bad = 0;
   logic        ack_force = 0;
   logic [15:0] smem [32];
   logic [15:0] ref_mem [32];
   logic [4:0]  cap_a;
   logic [15:0] cap_d;
   typedef struct {logic w; logic [4:0] a; logic [15:0] d;} rec_t;
   rec_t recs [$];
   gpmc_wb_bridge #(.ADDR_WIDTH(5), .DATA_WIDTH(16), .TIMEOUT(8), .ERR_DATA(16'hDEAD)) dut (
      .clk(clk), .reset(reset), .gpmc_csn(csn), .gpmc_advn(advn), .gpmc_wen(wen), .gpmc_oen(oen),
      .gpmc_ad_in(ad_in), .gpmc_ad_out(ad_out), .gpmc_ad_oe(ad_oe), .wbm_address(wb_addr),
      .wbm_writedata(wb_wdata), .wbm_readdata(wb_rdata), .wbm_write(wb_write), .wbm_cycle(wb_cycle),
      .wbm_ack(wb_ack), .timeout_err(terr)
   );
   always #5 clk = ~clk;
   assign wb_ack   = ack_force | ((lat >= 0) && wb_cycle && (cyc_cnt >= lat));
   assign wb_rdata = smem[wb_addr];
   // Wishbone slave memory plus a bus monitor
   always @(posedge clk) begin
      if (wb_cycle) begin
         if (cyc_cnt == 0) begin
            starts <= starts + 1;
            cap_a  <= wb_addr;
            cap_d  <= wb_wdata;
         end else if (wb_addr !== cap_a || (wb_write && wb_wdata !== cap_d)) stab_bad <= stab_bad + 1;
         if (wb_ack) begin
            recs.push_back('{w: wb_write, a: wb_addr, d: wb_wdata});
            if (wb_write) smem[wb_addr] <= wb_wdata;
         end
         cyc_cnt <= cyc_cnt + 1;
      end else begin
         if (cyc_cnt != 0) last_len <= cyc_cnt;
         cyc_cnt <= 0;
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic addr_phase(input logic [4:0] a);
      csn = 0; advn = 0; ad_in = {11'b0, a};
      tick(3);
      advn = 1;
      tick(3);
   endtask
   task automatic wr_check(input string tag, input logic [4:0] a, input logic [15:0] d, input int hold);
      int s0, n0;
      rec_t r;
      s0 = starts; n0 = recs.size();
      addr_phase(a);
      ad_in = d; wen = 0;
      tick(hold);
      wen = 1;
      tick(3);
      csn = 1;
      tick(3);
      ref_mem[a] = d;
      chk({tag, "_starts"}, starts - s0, 1);
      chk({tag, "_recs"}, recs.size() - n0, 1);
      if (recs.size() > n0) begin
         r = recs[n0];
         chk({tag, "_rec"}, {r.w, r.a, r.d}, {1'b1, a, d});
      end
      if (lat >= 0) chk({tag, "_len"}, last_len, lat + 1);
   endtask
   task automatic rd_check(input string tag, input logic [4:0] a, input logic [15:0] exp_d, input int exp_len);
      int s0, k;
      s0 = starts;
      addr_phase(a);
      oen = 0;
      tick(16);
      chk({tag, "_data"}, ad_out, exp_d);
      chk({tag, "_oe"}, ad_oe, 1);
      chk({tag, "_wr"}, recs.size() > 0 && lat >= 0 ? recs[$].w : 1'b0, 0);
      oen = 1;
      k = 0;
      while (ad_oe && k < 5) begin
         tick(1);
         k++;
      end
      chk({tag, "_oe_drop"}, k <= 3, 1);
      csn = 1;
      tick(3);
      chk({tag, "_starts"}, starts - s0, 1);
      chk({tag, "_len"}, last_len, exp_len);
   endtask
   initial begin
      int s0, n0;
      logic [15:0] v;
      logic [4:0]  a;
      for (int i = 0; i < 32; i++) begin
         v = 16'($urandom);
         smem[i] = v;
         ref_mem[i] = v;
      end
      tick(4);
      chk("rst_cycle", wb_cycle, 0);
      chk("rst_write", wb_write, 0);
      chk("rst_addr", wb_addr, 0);
      chk("rst_wdata", wb_wdata, 0);
      chk("rst_adout", ad_out, 0);
      chk("rst_oe", ad_oe, 0);
      chk("rst_terr", terr, 0);
      reset = 1;
      tick(3);
      // first write: pin-to-cycle latency and zero-wait single-clock transfer
      lat = 0;
      s0 = starts;
      addr_phase(0);
      ad_in = 16'h000F; wen = 0;
      tick(2);
      chk("lat_2clk", wb_cycle, 0);
      tick(1);
      chk("lat_3clk", wb_cycle, 1);
      chk("w0_write", wb_write, 1);
      chk("w0_addr", wb_addr, 0);
      chk("w0_wdata", wb_wdata, 16'h000F);
      tick(1);
      chk("w0_1clk", wb_cycle, 0);
      tick(8);
      wen = 1;
      tick(3);
      csn = 1;
      tick(3);
      ref_mem[0] = 16'h000F;
      chk("w0_starts", starts - s0, 1);
      chk("w0_len", last_len, 1);
      lat = 2;
      rd_check("rd3", 3, ref_mem[3], 3);
      lat = 1;
      wr_check("b2b1", 1, 16'hAAAA, 12);
      wr_check("b2b2", 2, 16'h5555, 40);
      chk("b2b_order", {recs[$-1].a, recs[$].a}, {5'd1, 5'd2});
      lat = 0;
      rd_check("rd1", 1, 16'hAAAA, 1);
      lat = -1;
      rd_check("tmo", 7, 16'hDEAD, 8);
      chk("tmo_err", terr, 1);
      lat = 3;
      wr_check("after_tmo", 4, 16'h1357, 12);
      chk("tmo_sticky", terr, 1);
      // strobe activity that must not start a Wishbone cycle
      s0 = starts; n0 = recs.size();
      wen = 0;
      tick(5);
      wen = 1;
      tick(4);
      csn = 0;
      tick(3);
      oen = 0;
      #2 oen = 1;
      tick(6);
      csn = 1;
      ack_force = 1;
      tick(3);
      ack_force = 0;
      tick(2);
      chk("glitch_starts", starts - s0, 0);
      chk("glitch_recs", recs.size() - n0, 0);
      chk("glitch_cycle", wb_cycle, 0);
      // reset while a read is waiting for its ack
      lat = -1;
      addr_phase(9);
      oen = 0;
      tick(5);
      chk("mid_incycle", wb_cycle, 1);
      reset = 0;
      #1;
      chk("mid_drop_now", wb_cycle, 0);
      tick(1);
      chk("mid_cycle", wb_cycle, 0);
      chk("mid_oe", ad_oe, 0);
      chk("mid_terr", terr, 0);
      chk("mid_addr", wb_addr, 0);
      oen = 1; csn = 1;
      tick(2);
      reset = 1;
      tick(3);
      lat = 1;
      rd_check("post_rst", 9, ref_mem[9], 2);
      chk("post_rst_terr", terr, 0);
      for (int i = 0; i < 12; i++) begin
         a = 5'($urandom_range(0, 31));
         v = 16'($urandom);
         lat = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) wr_check("rnd_wr", a, v, 12);
         else rd_check("rnd_rd", a, ref_mem[a], lat + 1);
      end
      chk("addr_stable", stab_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
